// File: rtl/i_decode_if.sv
// Pipeline boundary signals between fetch/write-back and the instruction decode stage.
// The decoder takes the slave side; the surrounding pipeline (or a bench) takes the master side.
interface i_decode_if;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        EX_MEM_PCSrc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] WB_write_data;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_readdat1;
  logic [31:0] ID_EX_readdat2;
  logic [31:0] ID_EX_sign_ext;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  ID_EX_rd;

  modport master (
    output IF_ID_instr, IF_ID_npc, EX_MEM_PCSrc, MEM_WB_RegWrite, MEM_WB_rd, WB_write_data,
    input  ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2,
           ID_EX_sign_ext, ID_EX_rt, ID_EX_rd
  );

  modport slave (
    input  IF_ID_instr, IF_ID_npc, EX_MEM_PCSrc, MEM_WB_RegWrite, MEM_WB_rd, WB_write_data,
    output ID_EX_wb, ID_EX_m, ID_EX_ex, ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2,
           ID_EX_sign_ext, ID_EX_rt, ID_EX_rd
  );
endinterface

// File: rtl/i_decode.sv
// MIPS-style ID stage: control decode, 32x32 register file with write-back bypass,
// and the ID/EX pipeline register with branch-flush bubble insertion.
module i_decode (
  input  logic       clk,
  input  logic       reset,
  i_decode_if.slave  bus
);

  // {ex[3:0], m[2:0], wb[1:0]} for the supported opcodes; anything else is a NOP.
  function automatic logic [8:0] decode_ctrl(input logic [5:0] opcode);
    logic [8:0] ctrl;
    case (opcode)
      6'h00:   ctrl = {4'b1100, 3'b000, 2'b10};
      6'h23:   ctrl = {4'b0001, 3'b010, 2'b11};
      6'h2B:   ctrl = {4'b0001, 3'b001, 2'b00};
      6'h04:   ctrl = {4'b0010, 3'b100, 2'b00};
      default: ctrl = 9'd0;
    endcase
    return ctrl;
  endfunction

  logic [31:0] regs_r [32];

  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic        wr_en_s;
  logic [31:0] rdat1_s;
  logic [31:0] rdat2_s;
  logic [8:0]  ctrl_s;

  logic [1:0]  wb_r;
  logic [2:0]  m_r;
  logic [3:0]  ex_r;
  logic [31:0] npc_r;
  logic [31:0] rdat1_r;
  logic [31:0] rdat2_r;
  logic [31:0] sext_r;
  logic [4:0]  rt_r;
  logic [4:0]  rd_r;

  assign rs_s    = bus.IF_ID_instr[25:21];
  assign rt_s    = bus.IF_ID_instr[20:16];
  assign wr_en_s = bus.MEM_WB_RegWrite && (bus.MEM_WB_rd != 5'd0);

  // Register read with same-edge write-back forwarding; r0 is hardwired to zero.
  always_comb begin
    rdat1_s = 32'd0;
    rdat2_s = 32'd0;
    ctrl_s  = 9'd0;
    if (rs_s == 5'd0) begin
      rdat1_s = 32'd0;
    end else if (wr_en_s && (bus.MEM_WB_rd == rs_s)) begin
      rdat1_s = bus.WB_write_data;
    end else begin
      rdat1_s = regs_r[rs_s];
    end
    if (rt_s == 5'd0) begin
      rdat2_s = 32'd0;
    end else if (wr_en_s && (bus.MEM_WB_rd == rt_s)) begin
      rdat2_s = bus.WB_write_data;
    end else begin
      rdat2_s = regs_r[rt_s];
    end
    if (bus.EX_MEM_PCSrc) begin
      ctrl_s = 9'd0;
    end else begin
      ctrl_s = decode_ctrl(bus.IF_ID_instr[31:26]);
    end
  end

  // Register file write port; flush does not gate it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      regs_r[bus.MEM_WB_rd] <= bus.WB_write_data;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_r    <= 4'd0;
      m_r     <= 3'd0;
      wb_r    <= 2'd0;
      npc_r   <= 32'd0;
      rdat1_r <= 32'd0;
      rdat2_r <= 32'd0;
      sext_r  <= 32'd0;
      rt_r    <= 5'd0;
      rd_r    <= 5'd0;
    end else begin
      ex_r    <= ctrl_s[8:5];
      m_r     <= ctrl_s[4:2];
      wb_r    <= ctrl_s[1:0];
      npc_r   <= bus.IF_ID_npc;
      rdat1_r <= rdat1_s;
      rdat2_r <= rdat2_s;
      sext_r  <= {{16{bus.IF_ID_instr[15]}}, bus.IF_ID_instr[15:0]};
      rt_r    <= bus.IF_ID_instr[20:16];
      rd_r    <= bus.IF_ID_instr[15:11];
    end
  end

  assign bus.ID_EX_ex       = ex_r;
  assign bus.ID_EX_m        = m_r;
  assign bus.ID_EX_wb       = wb_r;
  assign bus.ID_EX_npc      = npc_r;
  assign bus.ID_EX_readdat1 = rdat1_r;
  assign bus.ID_EX_readdat2 = rdat2_r;
  assign bus.ID_EX_sign_ext = sext_r;
  assign bus.ID_EX_rt       = rt_r;
  assign bus.ID_EX_rd       = rd_r;

endmodule
